// File: rtl/instr_fetch_buffer.sv
// instr_fetch_buffer: circular instruction buffer between imem and decode, with branch kill.
module instr_fetch_buffer #(
  parameter int          DEPTH     = 2,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] imem_instr_in,
  input  logic [31:0] imem_pc_in,
  input  logic        imem_valid_in,
  output logic        imem_ready_out,
  input  logic        stall_in,
  input  logic        branch_taken_in,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        valid_out,
  output logic        flush_out
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  typedef enum logic {RUN, KILL} state_t;
  state_t state;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic [31:0] instr_mem [DEPTH];
  logic [31:0] pc_mem [DEPTH];
  logic enq, deq;
  assign imem_ready_out = !rst_in && (count < FULL);
  assign enq = imem_valid_in && imem_ready_out && state == RUN && !branch_taken_in;
  assign flush_out = count == '0 || branch_taken_in || state == KILL;
  assign valid_out = !flush_out;
  assign deq = valid_out && !stall_in;
  assign instr_out = valid_out ? instr_mem[rd_ptr] : NOP_INSTR;
  assign pc_out = valid_out ? pc_mem[rd_ptr] : 32'h0;
  always_ff @(posedge clk_in) begin
    if (enq) begin
      instr_mem[wr_ptr] <= imem_instr_in;
      pc_mem[wr_ptr] <= imem_pc_in;
    end
  end
  // Branch wins over any same-cycle enqueue/dequeue; KILL drops the one in-flight response.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= RUN;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else if (branch_taken_in) begin
      state <= KILL;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      state <= RUN;
      wr_ptr <= enq ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= deq ? rd_ptr + AW'(1) : rd_ptr;
      count <= count + (AW+1)'(enq) - (AW+1)'(deq);
    end
  end
endmodule

// File: doc/instr_fetch_buffer.md
INSTR_FETCH_BUFFER -- requirements
Module: instr_fetch_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 2, number of buffered instruction entries (power of two, >= 2).
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0013, word driven on instr_out when no valid instruction is presented.
REQ-003 SHALL have port clk_in  input  1  single clock, all state updates on the rising edge.
REQ-004 SHALL have port rst_in  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port imem_instr_in  input  32  instruction word returned by instruction memory.
REQ-006 SHALL have port imem_pc_in  input  32  address of imem_instr_in.
REQ-007 SHALL have port imem_valid_in  input  1  imem_instr_in/imem_pc_in valid this cycle.
REQ-008 SHALL have port imem_ready_out  output  1  buffer can accept one word this cycle.
REQ-009 SHALL have port stall_in  input  1  decode stage not consuming this cycle.
REQ-010 SHALL have port branch_taken_in  input  1  redirect; discard all buffered and in-flight words.
REQ-011 SHALL have port instr_out  output  32  head instruction to decode stage.
REQ-012 SHALL have port pc_out  output  32  address of instr_out.
REQ-013 SHALL have port valid_out  output  1  instr_out holds a real instruction.
REQ-014 SHALL have port flush_out  output  1  decode must substitute NOP; drives the decode-stage flush input.

Function
REQ-015 SHALL store entries in a circular buffer with write pointer, read pointer and count (0..DEPTH); both pointers wrap modulo DEPTH.
REQ-016 SHALL assert imem_ready_out = !rst_in && (count < DEPTH); no combinational path from stall_in to imem_ready_out.
REQ-017 SHALL enqueue imem_instr_in/imem_pc_in at the edge when imem_valid_in && imem_ready_out && state==RUN && !branch_taken_in.
REQ-018 SHALL drive flush_out = (count==0) || branch_taken_in || state==KILL and valid_out = !flush_out.
REQ-019 SHALL drive instr_out/pc_out from the head entry when valid_out=1; otherwise instr_out=NOP_INSTR, pc_out=32'h0.
REQ-020 SHALL dequeue the head at the edge when valid_out && !stall_in.
REQ-021 SHALL give latency one cycle: a word enqueued at edge N is visible on instr_out in the cycle after edge N if buffer was empty.
REQ-022 SHALL keep count unchanged on simultaneous enqueue and dequeue, increment on enqueue only, decrement on dequeue only.
REQ-023 SHALL hold head entry and outputs stable while stall_in=1 and no branch_taken_in.
REQ-024 SHALL implement FSM states RUN and KILL; reset state RUN.
REQ-025 SHALL, on branch_taken_in=1 at an edge (any state), clear count and both pointers to 0 and enter KILL.
REQ-026 SHALL, in KILL, discard any imem_valid_in word (one outstanding memory response) and return to RUN at the next edge unless branch_taken_in=1 again.
REQ-027 SHALL give branch_taken_in priority over simultaneous enqueue and dequeue in the same cycle.
REQ-028 SHALL never overflow: imem_valid_in with imem_ready_out=0 is ignored and the word is lost (memory side is responsible for holding it).

Reset
REQ-029 SHALL, while rst_in=1, immediately force count=0, pointers=0, state=RUN, valid_out=0, flush_out=1, instr_out=NOP_INSTR, pc_out=0, imem_ready_out=0.
REQ-030 SHALL accept a word on the first rising edge after rst_in deasserts; reset asserted mid-operation discards all buffered entries.

Verification
REQ-031 SHALL cover: reset release, imem word 0x00500093 @pc 0x100, stall_in=0 -> next cycle instr_out=0x00500093, pc_out=0x100, valid_out=1, flush_out=0; following cycle NOP, flush_out=1.
REQ-032 SHALL cover: stall_in=1, three back-to-back words A,B,C -> A,B stored, imem_ready_out=0 after second, C ignored; release stall -> A then B out in order.
REQ-033 SHALL cover: full buffer (DEPTH=2), stall_in=0 with imem_valid_in=1 -> no enqueue that cycle, count 2->1, imem_ready_out=1 next cycle.
REQ-034 SHALL cover: two entries buffered, branch_taken_in pulse plus imem word next cycle -> flush_out=1 for both cycles, instr_out=0x00000013, word discarded, first word after KILL delivered normally.
REQ-035 SHALL cover: rst_in asserted mid-cycle with one entry buffered -> outputs reach reset values without a clock edge; post-release first word delivered with one-cycle latency.
REQ-036 SHALL cover: pointer wrap over 10 consecutive single-entry transfers -> order and pc_out values preserved.
